// File: rtl/zbt_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : zbt_arbiter
// Description : Shares one single-port ZBT SRAM between three requesters.
//               - Display read port: hard real-time and always granted on the
//                 cycle it requests. It is never stalled.
//               - Camera write stream: pulses are buffered in a small FIFO and
//                 drained in push order whenever the memory is free.
//               - Auxiliary read/write port: uses a req/ack handshake. It
//                 outranks queued camera writes once it has waited long enough.
//               At most one memory op is issued per cycle. The memory pins are
//               registered. Read data is returned to the requester that issued
//               the read, using a tag pipe that tracks the ZBT read latency.
// Ports       : clk_i, reset_i            clock, synchronous active-high reset
//               disp_req_i/addr_i         display read request (1-cycle pulse)
//               disp_rdata_o/valid_o      display read return
//               ntsc_we_i/addr_i/data_i   camera write push (addr bit 19 ignored)
//               ntsc_ovf_o                sticky: a camera write was dropped
//               aux_req_i/we_i/addr_i/wdata_i  aux request, held until ack
//               aux_ack_o                 aux op granted this cycle
//               aux_rdata_o/rvalid_o      aux read return
//               mem_addr_o/we_o/wdata_o   registered ZBT control/data
//               mem_rdata_i               ZBT read data (READ_LAT after addr)
// Revision    : 1.0 - initial release
// ============================================================================
module zbt_arbiter #(
  parameter int READ_LAT     = 2,
  parameter int WFIFO_DEPTH  = 4,
  parameter int AUX_MAX_WAIT = 16
) (
  input  logic        clk_i,
  input  logic        reset_i,
  // display read port
  input  logic        disp_req_i,
  input  logic [18:0] disp_addr_i,
  output logic [35:0] disp_rdata_o,
  output logic        disp_valid_o,
  // camera write stream
  input  logic        ntsc_we_i,
  input  logic [19:0] ntsc_addr_i,
  input  logic [35:0] ntsc_data_i,
  output logic        ntsc_ovf_o,
  // auxiliary port
  input  logic        aux_req_i,
  input  logic        aux_we_i,
  input  logic [18:0] aux_addr_i,
  input  logic [35:0] aux_wdata_i,
  output logic        aux_ack_o,
  output logic [35:0] aux_rdata_o,
  output logic        aux_rvalid_o,
  // ZBT pins
  output logic [18:0] mem_addr_o,
  output logic        mem_we_o,
  output logic [35:0] mem_wdata_o,
  input  logic [35:0] mem_rdata_i
);

  localparam int PTR_W  = $clog2(WFIFO_DEPTH);
  localparam int WAIT_W = $clog2(AUX_MAX_WAIT + 1);
  // The tag pipe is READ_LAT+1 deep. Each stage holds {is_disp, is_aux}.
  localparam int TAG_W  = 2 * (READ_LAT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(AUX_MAX_WAIT);

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_DISP = 2'd1,
    GNT_AUX  = 2'd2,
    GNT_FIFO = 2'd3
  } grant_e;

  grant_e grant;

  // --------------------------------------------------------------------------
  // Camera write FIFO. The pointers carry one extra wrap bit, which lets the
  // full and empty states be told apart.
  // --------------------------------------------------------------------------
  logic [18:0]    fifo_addr_q [WFIFO_DEPTH];
  logic [35:0]    fifo_data_q [WFIFO_DEPTH];
  logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
  logic           fifo_empty, fifo_full;
  logic           fifo_push, fifo_pop, fifo_drop;
  logic [18:0]    head_addr;
  logic [35:0]    head_data;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign head_addr  = fifo_addr_q[rd_ptr_q[PTR_W-1:0]];
  assign head_data  = fifo_data_q[rd_ptr_q[PTR_W-1:0]];

  // Bit 19 of the camera address selects a frame half upstream. The ZBT only
  // sees 19 address bits, so this bit is intentionally discarded.
  logic unused_ntsc_addr_msb;
  assign unused_ntsc_addr_msb = ntsc_addr_i[19];

  // --------------------------------------------------------------------------
  // Aux starvation counter and camera overflow flag
  // --------------------------------------------------------------------------
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              aux_urgent;
  logic              ovf_q, ovf_d;

  assign aux_urgent = (wait_cnt_q >= WAIT_LIMIT);

  // --------------------------------------------------------------------------
  // Grant: display > urgent aux > FIFO head > aux.
  // No grant is issued while in reset, so nothing new enters the pipe.
  // --------------------------------------------------------------------------
  always_comb begin
    grant = GNT_NONE;
    if (!reset_i) begin
      if (disp_req_i) begin
        grant = GNT_DISP;
      end else if (aux_req_i && aux_urgent) begin
        grant = GNT_AUX;
      end else if (!fifo_empty) begin
        grant = GNT_FIFO;
      end else if (aux_req_i) begin
        grant = GNT_AUX;
      end
    end
  end

  // FIFO bookkeeping. A push into a full FIFO is still accepted when the head
  // leaves in the same cycle, because the freed slot is the one being written.
  always_comb begin
    fifo_pop  = (grant == GNT_FIFO);
    fifo_push = ntsc_we_i && (!fifo_full || fifo_pop);
    fifo_drop = ntsc_we_i && fifo_full && !fifo_pop;
    wr_ptr_d  = wr_ptr_q + {{PTR_W{1'b0}}, fifo_push};
    rd_ptr_d  = rd_ptr_q + {{PTR_W{1'b0}}, fifo_pop};
    ovf_d     = ovf_q | fifo_drop;
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (grant == GNT_AUX) begin
      wait_cnt_d = '0;
    end else if (aux_req_i && (wait_cnt_q < WAIT_LIMIT)) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Memory command next-state. When idle, the address holds its last value
  // and only the write enable drops.
  // --------------------------------------------------------------------------
  logic [18:0] mem_addr_q, mem_addr_d;
  logic        mem_we_q, mem_we_d;
  logic [35:0] mem_wdata_q, mem_wdata_d;
  logic [1:0]  tag_in;

  always_comb begin
    mem_addr_d  = mem_addr_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    tag_in      = 2'b00;
    case (grant)
      GNT_DISP: begin
        mem_addr_d = disp_addr_i;
        tag_in     = 2'b10;
      end
      GNT_AUX: begin
        mem_addr_d = aux_addr_i;
        mem_we_d   = aux_we_i;
        if (aux_we_i) begin
          mem_wdata_d = aux_wdata_i;
        end else begin
          tag_in = 2'b01;
        end
      end
      GNT_FIFO: begin
        mem_addr_d  = head_addr;
        mem_we_d    = 1'b1;
        mem_wdata_d = head_data;
      end
      default: begin
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  logic [TAG_W-1:0] tag_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      wait_cnt_q  <= '0;
      ovf_q       <= 1'b0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      tag_q       <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      wait_cnt_q  <= wait_cnt_d;
      ovf_q       <= ovf_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      // Stage 0 lines up with mem_addr_o. The top stage lines up with the
      // cycle in which mem_rdata_i carries that read's data.
      tag_q       <= {tag_q[TAG_W-3:0], tag_in};
    end
  end

  // FIFO storage is data only. The pointers alone define its contents, so it
  // needs no reset.
  always_ff @(posedge clk_i) begin
    if (fifo_push) begin
      fifo_addr_q[wr_ptr_q[PTR_W-1:0]] <= ntsc_addr_i[18:0];
      fifo_data_q[wr_ptr_q[PTR_W-1:0]] <= ntsc_data_i;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs. Read data is forced to zero whenever it does not belong to the
  // requester.
  // --------------------------------------------------------------------------
  assign disp_valid_o = tag_q[TAG_W-1];
  assign aux_rvalid_o = tag_q[TAG_W-2];
  assign disp_rdata_o = disp_valid_o ? mem_rdata_i : '0;
  assign aux_rdata_o  = aux_rvalid_o ? mem_rdata_i : '0;
  assign aux_ack_o    = (grant == GNT_AUX);
  assign ntsc_ovf_o   = ovf_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_we_o     = mem_we_q;
  assign mem_wdata_o  = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_zbt_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_zbt_arbiter
// Description : Directed, table-driven bench for zbt_arbiter. It contains a
//               behavioural ZBT model with a 2-cycle read latency. Unwritten
//               locations read back as addr+100.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_zbt_arbiter;

  localparam int NV = 91;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        disp_req_i;
  logic [18:0] disp_addr_i;
  logic [35:0] disp_rdata_o;
  logic        disp_valid_o;
  logic        ntsc_we_i;
  logic [19:0] ntsc_addr_i;
  logic [35:0] ntsc_data_i;
  logic        ntsc_ovf_o;
  logic        aux_req_i;
  logic        aux_we_i;
  logic [18:0] aux_addr_i;
  logic [35:0] aux_wdata_i;
  logic        aux_ack_o;
  logic [35:0] aux_rdata_o;
  logic        aux_rvalid_o;
  logic [18:0] mem_addr_o;
  logic        mem_we_o;
  logic [35:0] mem_wdata_o;
  logic [35:0] mem_rdata_i;

  always #5 clk = ~clk;

  zbt_arbiter #(.READ_LAT(2), .WFIFO_DEPTH(4), .AUX_MAX_WAIT(16)) dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .disp_req_i   (disp_req_i),
    .disp_addr_i  (disp_addr_i),
    .disp_rdata_o (disp_rdata_o),
    .disp_valid_o (disp_valid_o),
    .ntsc_we_i    (ntsc_we_i),
    .ntsc_addr_i  (ntsc_addr_i),
    .ntsc_data_i  (ntsc_data_i),
    .ntsc_ovf_o   (ntsc_ovf_o),
    .aux_req_i    (aux_req_i),
    .aux_we_i     (aux_we_i),
    .aux_addr_i   (aux_addr_i),
    .aux_wdata_i  (aux_wdata_i),
    .aux_ack_o    (aux_ack_o),
    .aux_rdata_o  (aux_rdata_o),
    .aux_rvalid_o (aux_rvalid_o),
    .mem_addr_o   (mem_addr_o),
    .mem_we_o     (mem_we_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rdata_i  (mem_rdata_i)
  );

  // ZBT model: an address seen during cycle t returns its data during t+2
  logic [35:0] mem_model [logic [18:0]];
  logic [18:0] addr_d1;

  always @(posedge clk) begin
    if (mem_we_o === 1'b1) mem_model[mem_addr_o] = mem_wdata_o;
    if ($isunknown(addr_d1))             mem_rdata_i <= '0;
    else if (mem_model.exists(addr_d1))  mem_rdata_i <= mem_model[addr_d1];
    else                                 mem_rdata_i <= 36'(addr_d1) + 36'd100;
    addr_d1 <= mem_addr_o;
  end

  // Captures issued memory writes for the hand-written sequences
  logic        cap_en = 1'b0;
  logic [54:0] wq [$];
  always @(negedge clk) if (cap_en && mem_we_o === 1'b1) wq.push_back({mem_addr_o, mem_wdata_o});

  typedef struct {
    logic        rst, dreq, nwe, areq, awe;
    logic [18:0] daddr, aaddr;
    logic [19:0] naddr;
    logic [35:0] ndata, awdata;
    logic        en, zchk, e_dv, e_we, cm_addr, e_ovf, e_ack, e_rv;
    logic [35:0] e_dd, e_wd, e_rd;
    logic [18:0] e_maddr;
  } vec_t;

  vec_t vec [NV];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic void exp_we(int c, logic [18:0] a, logic [35:0] d);
    vec[c].e_we = 1'b1; vec[c].cm_addr = 1'b1; vec[c].e_maddr = a; vec[c].e_wd = d;
  endfunction

  function automatic void exp_rd(int c, logic [18:0] a);
    vec[c].cm_addr = 1'b1; vec[c].e_maddr = a;
  endfunction

  task automatic drive_idle();
    reset_i = 1'b0; disp_req_i = 1'b0; disp_addr_i = '0; ntsc_we_i = 1'b0;
    ntsc_addr_i = '0; ntsc_data_i = '0; aux_req_i = 1'b0; aux_we_i = 1'b0;
    aux_addr_i = '0; aux_wdata_i = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    cyc++;
    drive_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ack_at;
    int rv_at;
    drive_idle();
    reset_i = 1'b1;

    // ---------------- vector table ----------------
    for (int c = 0; c < NV; c++) begin
      vec[c]    = '{default: '0};
      vec[c].en = (c >= 1);
      vec[c].rst = (c <= 2) || (c == 81);
      vec[c].e_ovf = (c >= 35) && (c <= 81);
    end
    vec[1].zchk = 1'b1;
    vec[82].zchk = 1'b1; exp_rd(82, 19'h0);
    // 1: three back-to-back display reads
    for (int i = 0; i < 3; i++) begin
      vec[10+i].dreq = 1'b1; vec[10+i].daddr = 19'(5 + i);
      exp_rd(11 + i, 19'(5 + i));
      vec[13+i].e_dv = 1'b1; vec[13+i].e_dd = 36'(105 + i);
    end
    // 2: single camera write, bit 19 dropped; address holds when idle
    vec[20].nwe = 1'b1; vec[20].naddr = 20'h80010; vec[20].ndata = 36'hA;
    exp_we(22, 19'h10, 36'hA);
    exp_rd(23, 19'h10);
    // 3: display hogs memory, fifth camera push overflows
    for (int i = 0; i < 10; i++) begin
      vec[30+i].dreq = 1'b1; vec[30+i].daddr = 19'(8'h40 + i);
      exp_rd(31 + i, 19'(8'h40 + i));
      vec[33+i].e_dv = 1'b1; vec[33+i].e_dd = 36'(8'h40 + i + 100);
    end
    for (int i = 0; i < 5; i++) begin
      vec[30+i].nwe = 1'b1; vec[30+i].naddr = 20'(20'h80020 + i); vec[30+i].ndata = 36'(8'hC0 + i);
    end
    for (int i = 0; i < 4; i++) exp_we(41 + i, 19'(8'h20 + i), 36'(8'hC0 + i));
    // 4: aux read waits behind a never-empty FIFO until it becomes urgent
    for (int c = 49; c <= 66; c++) begin
      vec[c].nwe = 1'b1; vec[c].naddr = 20'(12'h100 + c - 49); vec[c].ndata = 36'(12'h200 + c - 49);
    end
    for (int c = 50; c <= 66; c++) begin
      vec[c].areq = 1'b1; vec[c].aaddr = 19'h3000;
    end
    for (int c = 51; c <= 66; c++) exp_we(c, 19'(12'h100 + c - 51), 36'(12'h200 + c - 51));
    vec[66].e_ack = 1'b1;
    exp_rd(67, 19'h3000);
    exp_we(68, 19'h110, 36'h210);
    exp_we(69, 19'h111, 36'h211);
    vec[69].e_rv = 1'b1; vec[69].e_rd = 36'h3064;
    // 5: aux write then read-back of the same address
    vec[70].areq = 1'b1; vec[70].awe = 1'b1; vec[70].aaddr = 19'h3100; vec[70].awdata = 36'hBEEF;
    vec[70].e_ack = 1'b1;
    exp_we(71, 19'h3100, 36'hBEEF);
    vec[72].areq = 1'b1; vec[72].aaddr = 19'h3100;
    vec[72].e_ack = 1'b1;
    exp_rd(73, 19'h3100);
    vec[75].e_rv = 1'b1; vec[75].e_rd = 36'hBEEF;
    // 6: reset abandons an in-flight display read (cycle 83 expects no valid)
    vec[80].dreq = 1'b1; vec[80].daddr = 19'h50;
    exp_rd(81, 19'h50);

    // ---------------- apply table ----------------
    for (int c = 0; c < NV; c++) begin
      @(posedge clk);
      #1;
      cyc = c;
      reset_i = vec[c].rst; disp_req_i = vec[c].dreq; disp_addr_i = vec[c].daddr;
      ntsc_we_i = vec[c].nwe; ntsc_addr_i = vec[c].naddr; ntsc_data_i = vec[c].ndata;
      aux_req_i = vec[c].areq; aux_we_i = vec[c].awe; aux_addr_i = vec[c].aaddr;
      aux_wdata_i = vec[c].awdata;
      @(negedge clk);
      if (vec[c].en) begin
        chk("disp_valid", 64'(disp_valid_o), 64'(vec[c].e_dv));
        if (vec[c].e_dv) chk("disp_rdata", 64'(disp_rdata_o), 64'(vec[c].e_dd));
        chk("mem_we", 64'(mem_we_o), 64'(vec[c].e_we));
        if (vec[c].cm_addr) chk("mem_addr", 64'(mem_addr_o), 64'(vec[c].e_maddr));
        if (vec[c].e_we) chk("mem_wdata", 64'(mem_wdata_o), 64'(vec[c].e_wd));
        chk("ntsc_ovf", 64'(ntsc_ovf_o), 64'(vec[c].e_ovf));
        chk("aux_ack", 64'(aux_ack_o), 64'(vec[c].e_ack));
        chk("aux_rvalid", 64'(aux_rvalid_o), 64'(vec[c].e_rv));
        if (vec[c].e_rv) chk("aux_rdata", 64'(aux_rdata_o), 64'(vec[c].e_rd));
        if (vec[c].zchk) begin
          chk("reset_disp_rdata", 64'(disp_rdata_o), 64'h0);
          chk("reset_aux_rdata", 64'(aux_rdata_o), 64'h0);
          chk("reset_mem_wdata", 64'(mem_wdata_o), 64'h0);
        end
      end
    end

    // ---- sequence A: push into a full FIFO while the head pops: no drop ----
    wq.delete();
    cap_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      disp_req_i  = (i < 5);
      disp_addr_i = 19'(8'h60 + i);
      if (i < 4 || i == 5) begin
        ntsc_we_i   = 1'b1;
        ntsc_addr_i = 20'(12'h400 + (i < 4 ? i : 4));
        ntsc_data_i = 36'(12'h500 + (i < 4 ? i : 4));
      end
    end
    for (int i = 0; i < 10; i++) next_cycle();
    @(negedge clk);
    cap_en = 1'b0;
    chk("full_push_pop_ovf", 64'(ntsc_ovf_o), 64'h0);
    chk("full_push_pop_count", 64'(wq.size()), 64'd5);
    for (int j = 0; j < 5 && j < wq.size(); j++)
      chk("full_push_pop_order", 64'(wq[j]), 64'({19'(12'h400 + j), 36'(12'h500 + j)}));

    // ---- sequence B: display outranks even an urgent aux request ----
    ack_at = -1;
    for (int n = 0; n < 40 && ack_at < 0; n++) begin
      next_cycle();
      disp_req_i  = (n < 20);
      disp_addr_i = 19'h70;
      aux_req_i   = 1'b1;
      aux_addr_i  = 19'h3100;
      @(negedge clk);
      if (aux_ack_o === 1'b1) ack_at = n;
    end
    chk("aux_ack_after_display", 64'(ack_at), 64'd20);
    rv_at = -1;
    for (int m = 1; m <= 8; m++) begin
      next_cycle();
      @(negedge clk);
      if (aux_rvalid_o === 1'b1 && rv_at < 0) begin
        rv_at = m;
        chk("aux_rdata_seqB", 64'(aux_rdata_o), 64'hBEEF);
      end
    end
    chk("aux_rvalid_latency", 64'(rv_at), 64'd3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
